// File: rtl/alu_seq_if.sv
// Operand/result bus of the multi-cycle ALU, with a master (pipeline) view
// and a slave (ALU) view.
interface alu_seq_if #(
    parameter int DATA_WIDTH = 32
);
    // A transfer happens on a rising edge where valid && ready. The source
    // keeps valid and its payload stable until that edge. The sink may raise
    // or drop ready at any time.
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [3:0]            alu_op;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] result;
    logic                  zero;
    logic                  carry;
    logic                  overflow;

    modport master (
        output in_valid, a, b, alu_op, out_ready,
        input  in_ready, out_valid, result, zero, carry, overflow
    );

    modport slave (
        input  in_valid, a, b, alu_op, out_ready,
        output in_ready, out_valid, result, zero, carry, overflow
    );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle RV32I-style ALU. Simple ops finish in one registered cycle.
// MUL/MULHU use shift-add and DIV/REM use restoring division, one bit per cycle.
module alu_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    alu_seq_if.slave   bus,
    output logic [1:0] o_dbg_state
);
    localparam int W = DATA_WIDTH;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_AND   = 4'h2;
    localparam logic [3:0] OP_OR    = 4'h3;
    localparam logic [3:0] OP_XOR   = 4'h4;
    localparam logic [3:0] OP_SLL   = 4'h5;
    localparam logic [3:0] OP_SRL   = 4'h6;
    localparam logic [3:0] OP_SRA   = 4'h7;
    localparam logic [3:0] OP_SLT   = 4'h8;
    localparam logic [3:0] OP_SLTU  = 4'h9;
    localparam logic [3:0] OP_MUL   = 4'hA;
    localparam logic [3:0] OP_MULHU = 4'hB;
    localparam logic [3:0] OP_DIVU  = 4'hC;
    localparam logic [3:0] OP_REMU  = 4'hD;
    localparam logic [3:0] OP_DIV   = 4'hE;
    localparam logic [3:0] OP_REM   = 4'hF;

    localparam logic [W-1:0] W_MIN  = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] W_ONES = {W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [SHAMT_W-1:0] r_cnt;
    logic [3:0]         r_op;
    logic [W-1:0]       r_opnd;
    logic [2*W-1:0]     r_acc;
    logic               r_neg;
    logic [W-1:0]       r_result;
    logic               r_zero;
    logic               r_carry;
    logic               r_ovf;

    logic               w_iter_last;
    logic [W:0]         w_sum;
    logic [W:0]         w_diff;
    logic [SHAMT_W-1:0] w_shamt;
    logic               w_is_mul_in;
    logic               w_is_div_in;
    logic               w_signed_div;
    logic               w_div_zero;
    logic               w_div_ovf;
    logic               w_fast;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [W-1:0]       w_a_mag;
    logic [W-1:0]       w_b_mag;
    logic [W-1:0]       w_imm_result;
    logic               w_imm_carry;
    logic               w_imm_ovf;

    logic [W:0]         w_mul_sum;
    logic [2*W-1:0]     w_mul_next;
    logic [W:0]         w_div_shift;
    logic [W:0]         w_div_trial;
    logic               w_div_ge;
    logic [2*W-1:0]     w_div_next;
    logic [2*W-1:0]     w_acc_next;
    logic [W-1:0]       w_final;

    assign w_iter_last = (r_cnt == SHAMT_W'(W - 1));

    // Operand decode and the single-cycle result path, evaluated while IDLE.
    always_comb begin
        w_sum        = {1'b0, bus.a} + {1'b0, bus.b};
        w_diff       = {1'b0, bus.a} - {1'b0, bus.b};
        w_shamt      = bus.b[SHAMT_W-1:0];
        w_is_mul_in  = (bus.alu_op == OP_MUL) || (bus.alu_op == OP_MULHU);
        w_is_div_in  = (bus.alu_op[3:2] == 2'b11);
        w_signed_div = w_is_div_in && bus.alu_op[1];
        w_div_zero   = (bus.b == '0);
        w_div_ovf    = w_signed_div && (bus.a == W_MIN) && (bus.b == W_ONES);
        w_fast       = !(w_is_mul_in || (w_is_div_in && !w_div_zero && !w_div_ovf));
        w_a_neg      = w_signed_div && bus.a[W-1];
        w_b_neg      = w_signed_div && bus.b[W-1];
        w_a_mag      = w_a_neg ? -bus.a : bus.a;
        w_b_mag      = w_b_neg ? -bus.b : bus.b;
        w_imm_result = '0;
        w_imm_carry  = 1'b0;
        w_imm_ovf    = 1'b0;
        case (bus.alu_op)
            OP_ADD: begin
                w_imm_result = w_sum[W-1:0];
                w_imm_carry  = w_sum[W];
                w_imm_ovf    = (bus.a[W-1] == bus.b[W-1]) && (w_sum[W-1] != bus.a[W-1]);
            end
            OP_SUB: begin
                w_imm_result = w_diff[W-1:0];
                w_imm_carry  = w_diff[W];
                w_imm_ovf    = (bus.a[W-1] != bus.b[W-1]) && (w_diff[W-1] != bus.a[W-1]);
            end
            OP_AND:  w_imm_result = bus.a & bus.b;
            OP_OR:   w_imm_result = bus.a | bus.b;
            OP_XOR:  w_imm_result = bus.a ^ bus.b;
            OP_SLL:  w_imm_result = bus.a << w_shamt;
            OP_SRL:  w_imm_result = bus.a >> w_shamt;
            OP_SRA:  w_imm_result = $signed(bus.a) >>> w_shamt;
            OP_SLT:  w_imm_result = {{(W-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_SLTU: w_imm_result = {{(W-1){1'b0}}, (bus.a < bus.b)};
            // Only the special divide cases reach here with w_fast set.
            OP_DIVU, OP_DIV: w_imm_result = w_div_zero ? W_ONES : W_MIN;
            OP_REMU, OP_REM: w_imm_result = w_div_zero ? bus.a : '0;
            default: w_imm_result = '0;
        endcase
    end

    // One iteration step. r_acc holds {high, low}: for multiply the partial
    // product and the remaining multiplier bits, for divide the partial
    // remainder and the dividend being shifted into a quotient.
    always_comb begin
        w_mul_sum   = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opnd} : {(W+1){1'b0}});
        w_mul_next  = {w_mul_sum, r_acc[W-1:1]};
        w_div_shift = {r_acc[2*W-1:W], r_acc[W-1]};
        w_div_trial = w_div_shift - {1'b0, r_opnd};
        w_div_ge    = !w_div_trial[W];
        w_div_next  = {(w_div_ge ? w_div_trial[W-1:0] : w_div_shift[W-1:0]),
                       r_acc[W-2:0], w_div_ge};
        w_acc_next  = (r_op[3:1] == 3'b101) ? w_mul_next : w_div_next;
        w_final     = '0;
        case (r_op)
            OP_MUL:   w_final = w_acc_next[W-1:0];
            OP_MULHU: w_final = w_acc_next[2*W-1:W];
            OP_DIVU:  w_final = w_acc_next[W-1:0];
            OP_REMU:  w_final = w_acc_next[2*W-1:W];
            OP_DIV:   w_final = r_neg ? -w_acc_next[W-1:0] : w_acc_next[W-1:0];
            OP_REM:   w_final = r_neg ? -w_acc_next[2*W-1:W] : w_acc_next[2*W-1:W];
            default:  w_final = '0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid) w_state_next = w_fast ? DONE : BUSY;
            BUSY:    if (w_iter_last) w_state_next = DONE;
            DONE:    if (bus.out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        if (flush) w_state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_op     <= '0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_neg    <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (flush) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_op  <= bus.alu_op;
                        r_cnt <= '0;
                        if (w_fast) begin
                            r_result <= w_imm_result;
                            r_zero   <= (w_imm_result == '0);
                            r_carry  <= w_imm_carry;
                            r_ovf    <= w_imm_ovf;
                        end else if (w_is_mul_in) begin
                            r_opnd <= bus.a;
                            r_acc  <= {{W{1'b0}}, bus.b};
                            r_neg  <= 1'b0;
                        end else begin
                            r_opnd <= w_b_mag;
                            r_acc  <= {{W{1'b0}}, w_a_mag};
                            // Quotient sign is a^b; remainder follows the dividend.
                            r_neg  <= bus.alu_op[0] ? w_a_neg : (w_a_neg ^ w_b_neg);
                        end
                    end
                end
                BUSY: begin
                    r_acc <= w_acc_next;
                    if (w_iter_last) begin
                        r_cnt    <= '0;
                        r_result <= w_final;
                        r_zero   <= (w_final == '0);
                        r_carry  <= 1'b0;
                        r_ovf    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;
    assign bus.carry     = r_carry;
    assign bus.overflow  = r_ovf;
    assign o_dbg_state   = r_state;
endmodule
